// File: rtl/pc_fetch_pkg.sv
// Shared types and defaults for the program-counter / fetch sequencer.
// Contents: fetch FSM state enum, default PC width and start address, pc_t.
// Optional feature macro used by pc_fetch_ctrl: PC_FETCH_CALL_LINK_EN.
package pc_fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } fetch_state_t;

  localparam int unsigned PC_W_DEF     = 8;
  localparam logic [7:0]  START_PC_DEF = 8'h00;

  typedef logic [PC_W_DEF-1:0] pc_t;

endpackage : pc_fetch_pkg

// File: rtl/pc_fetch_ctrl.sv
// Program-counter / fetch sequencer. Holds the PC that addresses instruction
// memory, steps it every active cycle, loads the lookup-table target on a
// taken branch and runs the start/done program handshake.
//
// Ports:
//   clk, rst_n     clock (rising edge), asynchronous active-low reset
//   start          begin a program run (accepted in IDLE or DONE)
//   stall          hold PC this cycle (RUN only)
//   branch_taken   branch resolved taken; load target
//   target         absolute branch target
//   halt           current instruction is halt; go to DONE
//   call, ret      link save / return (used only with PC_FETCH_CALL_LINK_EN)
//   pc             instruction address (registered)
//   running        high in RUN (registered)
//   done           high in DONE (registered)
//   pc_wrap        sticky: PC incremented past all-ones during this run
//
// Macro PC_FETCH_CALL_LINK_EN: adds a one-deep link register. A taken branch
// with call saves pc+1; ret jumps to the saved link and outranks a branch.
module pc_fetch_ctrl
  import pc_fetch_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEF,
  parameter logic [PC_W-1:0] START_PC = PC_W'(START_PC_DEF)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            stall,
  input  logic            branch_taken,
  input  logic [PC_W-1:0] target,
  input  logic            halt,
  input  logic            call,
  input  logic            ret,
  output logic [PC_W-1:0] pc,
  output logic            running,
  output logic            done,
  output logic            pc_wrap
);

  fetch_state_t    state, state_n;
  logic [PC_W-1:0] pc_n;
  logic            wrap_n;
  logic            running_n;
  logic            done_n;
  logic [PC_W:0]   pc_inc;

`ifdef PC_FETCH_CALL_LINK_EN
  logic [PC_W-1:0] link, link_n;
`else
  // call/ret exist on the port list only so both builds share one interface.
  logic unused_call_ret;
  assign unused_call_ret = call ^ ret;
`endif

  // Next-state and next-pc priority mux: halt > stall > ret > branch > increment.
  always_comb begin
    state_n = state;
    pc_n    = pc;
    wrap_n  = pc_wrap;
`ifdef PC_FETCH_CALL_LINK_EN
    link_n  = link;
`endif
    // Extra MSB carries the all-ones -> zero wrap indication.
    pc_inc  = (PC_W+1)'({1'b0, pc}) + (PC_W+1)'(1);

    unique case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_n = S_RUN;
          pc_n    = START_PC;
          wrap_n  = 1'b0;
        end
      end
      S_RUN: begin
        if (halt) begin
          state_n = S_DONE;
        end else if (!stall) begin
`ifdef PC_FETCH_CALL_LINK_EN
          if (ret) begin
            pc_n = link;
          end else if (branch_taken) begin
            pc_n = target;
            if (call) link_n = pc_inc[PC_W-1:0];
          end else begin
            pc_n = pc_inc[PC_W-1:0];
            if (pc_inc[PC_W]) wrap_n = 1'b1;
          end
`else
          if (branch_taken) begin
            pc_n = target;
          end else begin
            pc_n = pc_inc[PC_W-1:0];
            if (pc_inc[PC_W]) wrap_n = 1'b1;
          end
`endif
        end
      end
      default: state_n = S_IDLE;
    endcase

    running_n = (state_n == S_RUN);
    done_n    = (state_n == S_DONE);
  end

  // State, PC, flags and link register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      pc      <= START_PC;
      running <= 1'b0;
      done    <= 1'b0;
      pc_wrap <= 1'b0;
`ifdef PC_FETCH_CALL_LINK_EN
      link    <= START_PC;
`endif
    end else begin
      state   <= state_n;
      pc      <= pc_n;
      running <= running_n;
      done    <= done_n;
      pc_wrap <= wrap_n;
`ifdef PC_FETCH_CALL_LINK_EN
      link    <= link_n;
`endif
    end
  end

endmodule : pc_fetch_ctrl

// File: tb/tb_pc_fetch_ctrl.sv
// Self-checking bench for pc_fetch_ctrl: directed scenarios with literal
// expectations followed by randomized stimulus, all compared each cycle
// against a behavioural model. Honours PC_FETCH_CALL_LINK_EN.
module tb_pc_fetch_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       stall = 1'b0;
  logic       branch_taken = 1'b0;
  logic [7:0] target = 8'h00;
  logic       halt = 1'b0;
  logic       call = 1'b0;
  logic       ret = 1'b0;
  logic [7:0] pc;
  logic       running;
  logic       done;
  logic       pc_wrap;

  pc_fetch_ctrl #(.PC_W(8), .START_PC(8'h00)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .branch_taken(branch_taken), .target(target), .halt(halt),
    .call(call), .ret(ret), .pc(pc), .running(running), .done(done),
    .pc_wrap(pc_wrap)
  );

  always #5 clk = ~clk;

`ifdef PC_FETCH_CALL_LINK_EN
  localparam bit CL = 1'b1;
`else
  localparam bit CL = 1'b0;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  bit cmp_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", name, act, exp, $time);
  endtask

  // Behavioural model: mode 0=idle, 1=run, 2=done; pc as plain integer.
  int m_mode = 0;
  int m_pc   = 0;
  int m_wrap = 0;
  int m_link = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0; m_pc = 0; m_wrap = 0; m_link = 0;
    end else if (m_mode != 1) begin
      if (start) begin m_mode = 1; m_pc = 0; m_wrap = 0; end
    end else if (halt) begin
      m_mode = 2;
    end else if (stall) begin
      // pc holds, everything else dropped
    end else if (CL && ret) begin
      m_pc = m_link;
    end else if (branch_taken) begin
      if (CL && call) m_link = (m_pc + 1) % 256;
      m_pc = int'(target);
    end else begin
      if (m_pc == 255) m_wrap = 1;
      m_pc = (m_pc + 1) % 256;
    end
  end

  // Every-cycle comparison of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cmp_pc",      int'(pc),      m_pc);
      chk("cmp_running", int'(running), int'(m_mode == 1));
      chk("cmp_done",    int'(done),    int'(m_mode == 2));
      chk("cmp_pc_wrap", int'(pc_wrap), m_wrap);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Literal expectation pinned on both the DUT and the model.
  task automatic expect_pc(input string name, input int val);
    chk(name, int'(pc), val);
    chk({name, "_model"}, m_pc, val);
  endtask

  task automatic expect_flags(input string name, input int r, input int d, input int w);
    chk({name, "_running"}, int'(running), r);
    chk({name, "_done"},    int'(done),    d);
    chk({name, "_wrap"},    int'(pc_wrap), w);
  endtask

  initial begin
    #1 rst_n = 1'b0;
    cmp_en = 1'b1;
    #11;
    expect_pc("reset_pc", 'h00);
    expect_flags("reset", 0, 0, 0);
    tick();
    rst_n = 1'b1;

    // 1: start, free run
    start = 1'b1; tick(); start = 1'b0;
    expect_pc("t1_pc0", 'h00); expect_flags("t1_run", 1, 0, 0);
    tick(); expect_pc("t1_pc1", 'h01);
    tick(); expect_pc("t1_pc2", 'h02);
    tick(); expect_pc("t1_pc3", 'h03);

    // 2: stall drops branch, then branch takes effect
    stall = 1'b1; branch_taken = 1'b1; target = 8'h48; tick();
    expect_pc("t2_stall", 'h03);
    stall = 1'b0; tick(); expect_pc("t2_branch", 'h48);
    branch_taken = 1'b0; tick(); expect_pc("t2_inc", 'h49);

    // 3: wrap past FF, sticky until next start
    branch_taken = 1'b1; target = 8'hFE; tick(); branch_taken = 1'b0;
    expect_pc("t3_fe", 'hFE);
    tick(); expect_pc("t3_ff", 'hFF); expect_flags("t3_ff", 1, 0, 0);
    tick(); expect_pc("t3_00", 'h00); expect_flags("t3_wrap", 1, 0, 1);
    halt = 1'b1; tick(); halt = 1'b0;
    expect_flags("t3_done", 0, 1, 1);
    start = 1'b1; tick(); start = 1'b0;
    expect_pc("t3_restart", 'h00); expect_flags("t3_restart", 1, 0, 0);

    // 4: halt beats branch
    branch_taken = 1'b1; target = 8'h10; tick();
    expect_pc("t4_10", 'h10);
    halt = 1'b1; target = 8'h7E; tick(); halt = 1'b0; branch_taken = 1'b0;
    expect_pc("t4_halt", 'h10); expect_flags("t4_halt", 0, 1, 0);
    tick(); expect_pc("t4_hold", 'h10);
    start = 1'b1; tick(); start = 1'b0;
    expect_pc("t4_start", 'h00); expect_flags("t4_start", 1, 0, 0);

    // 5: async reset between edges
    branch_taken = 1'b1; target = 8'hFF; tick(); branch_taken = 1'b0;
    tick(); expect_flags("t5_wrap", 1, 0, 1);
    branch_taken = 1'b1; target = 8'h5C; tick(); branch_taken = 1'b0;
    expect_pc("t5_5c", 'h5C);
    #2 rst_n = 1'b0;
    #1 expect_pc("t5_rst", 'h00); expect_flags("t5_rst", 0, 0, 0);
    tick(); rst_n = 1'b1;
    tick(); expect_flags("t5_idle", 0, 0, 0);

    // 6: call / ret
    start = 1'b1; tick(); start = 1'b0;
    branch_taken = 1'b1; target = 8'h20; tick(); expect_pc("t6_20", 'h20);
    call = 1'b1; target = 8'h60; tick(); call = 1'b0; branch_taken = 1'b0;
    expect_pc("t6_60", 'h60);
    tick(); tick(); expect_pc("t6_62", 'h62);
    ret = 1'b1; tick(); ret = 1'b0;
    expect_pc("t6_ret", CL ? 'h21 : 'h63);
    tick(); expect_pc("t6_after", CL ? 'h22 : 'h64);

    // Randomized phase
    for (int i = 0; i < 4000; i++) begin
      start        = ($urandom_range(0, 9) == 0);
      stall        = ($urandom_range(0, 99) < 15);
      halt         = ($urandom_range(0, 59) == 0);
      branch_taken = ($urandom_range(0, 5) == 0);
      call         = ($urandom_range(0, 2) == 0);
      ret          = ($urandom_range(0, 11) == 0);
      if ($urandom_range(0, 3) == 0) target = 8'(8'hF0 + $urandom_range(0, 15));
      else                           target = 8'($urandom);
      if ($urandom_range(0, 499) == 0) begin
        #2 rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end else begin
        tick();
      end
    end

    start = 1'b0; stall = 1'b0; halt = 1'b0; branch_taken = 1'b0;
    call = 1'b0; ret = 1'b0;
    tick();
    cmp_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_pc_fetch_ctrl
